flag_gen: RTL and testbench
===========================

FLAG_GEN -- requirements
Module: flag_gen

Interface
REQ-001 Parameter WIDTH, default 16: datapath width of ALU result and operands.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 upd_en  input  1  single-cycle ALU result valid this cycle; request to update flags.
REQ-005 op_class  input  2  00 ADD, 01 SUB, 10 LOGIC, 11 SHIFT.
REQ-006 result  input  WIDTH  ALU result.
REQ-007 a_msb, b_msb  input  1 each  operand sign bits (SUB means a minus b).
REQ-008 mc_issue  input  1  multi-cycle ADD/SUB issued; flags go pending.
REQ-009 mc_done  input  1  multi-cycle result valid on result/a_msb/b_msb/op_class.
REQ-010 stall  input  1  pipeline stall; suppresses all updates.
REQ-011 flush  input  1  squash in-flight op.
REQ-012 N, V, Z  output  1 each  registered condition flags consumed by the branch evaluator.
REQ-013 flags_valid  output  1  high when N/V/Z reflect all issued flag-setting ops.

Function
REQ-014 Z_next SHALL be 1 iff result equals zero across all WIDTH bits.
REQ-015 N_next SHALL equal result[WIDTH-1].
REQ-016 ADD: V_next SHALL be (a_msb == b_msb) and (result[WIDTH-1] != a_msb).
REQ-017 SUB: V_next SHALL be (a_msb != b_msb) and (result[WIDTH-1] != a_msb).
REQ-018 ADD/SUB SHALL write N, V, Z; LOGIC/SHIFT SHALL write Z only, N and V hold.
REQ-019 Flags SHALL update on the rising edge after the qualifying input; latency one cycle, no combinational bypass.
REQ-020 FSM states: IDLE, PEND.
REQ-021 IDLE: upd_en and not stall -> write flags, stay IDLE.
REQ-022 IDLE: mc_issue and not stall -> PEND, flags unchanged; mc_issue has priority over simultaneous upd_en (upd_en dropped).
REQ-023 PEND: mc_done and not stall -> write flags per REQ-014..018, go IDLE.
REQ-024 PEND: upd_en and mc_issue SHALL be ignored.
REQ-025 flush SHALL override all: PEND -> IDLE with flags unchanged; IDLE flags unchanged that cycle.
REQ-026 stall high: no state or flag change, except flush still acts.
REQ-027 mc_done in IDLE SHALL be ignored.
REQ-028 flags_valid SHALL be 1 in IDLE, 0 in PEND (registered state decode, no input path).

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, N=0, V=0, Z=0, flags_valid=1.
REQ-030 Reset asserted mid-PEND SHALL abandon the op; a later mc_done SHALL be ignored.
REQ-031 Deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-032 Shared package SHALL hold op_class encodings and FSM state encoding; the branch evaluator's condition codes also live there.
REQ-033 One sub-module flag_calc (combinational N/V/Z_next from result, msbs, op_class); FSM and flag registers in flag_gen.

Verification
REQ-034 Reset: rst_n low mid-cycle -> N=V=Z=0, flags_valid=1 immediately, no clock needed.
REQ-035 ADD 0x7FFF+0x0001, result 0x8000, upd_en -> next cycle N=1, V=1, Z=0.
REQ-036 SUB 0x0005-0x0005, result 0x0000 -> Z=1, N=0, V=0; then LOGIC result 0x00F0 -> Z=0, N and V unchanged.
REQ-037 mc_issue -> flags_valid=0; 3 cycles later mc_done with SUB 0x8000-0x0001 result 0x7FFF -> V=1, N=0, Z=0, flags_valid=1.
REQ-038 upd_en with stall=1 -> flags unchanged; same op with stall=0 -> updated next cycle.
REQ-039 mc_issue, then flush in PEND -> flags_valid=1 next cycle, flags unchanged, later mc_done ignored.

Source files
------------

// File: rtl/flag_gen_pkg.sv
// Shared encodings for the condition-flag path: ALU op classes, the flag
// FSM state encoding, and the branch evaluator's condition codes.
package flag_gen_pkg;

  // ALU operation classes as presented on op_class
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  // Flag FSM: IDLE means N/V/Z are current, PEND means a multi-cycle op is outstanding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Condition codes consumed by the branch evaluator
  typedef enum logic [2:0] {
    CC_EQ = 3'd0,  // Z
    CC_NE = 3'd1,  // !Z
    CC_MI = 3'd2,  // N
    CC_PL = 3'd3,  // !N
    CC_VS = 3'd4,  // V
    CC_VC = 3'd5,  // !V
    CC_LT = 3'd6,  // N != V
    CC_GE = 3'd7   // N == V
  } cond_t;

  // Evaluate a condition code against a flag set
  function automatic logic cond_true(cond_t cc, logic n, logic v, logic z);
    case (cc)
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_LT:   return n != v;
      default: return n == v;
    endcase
  endfunction

  // True for op classes that write N and V as well as Z
  function automatic logic writes_nv(logic [1:0] op_class);
    return (op_class == OP_ADD) || (op_class == OP_SUB);
  endfunction

endpackage

// File: rtl/flag_gen_calc.sv
// Combinational next-flag computation from an ALU result and operand signs.
module flag_calc
  import flag_gen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] result,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [1:0]       op_class,
  output logic             n_next,
  output logic             v_next,
  output logic             z_next,
  output logic             nv_wr
);

  // Derive N/V/Z and whether this op class is allowed to touch N and V
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    v_next = 1'b0;
    n_next = result[WIDTH-1];
    z_next = (result == '0);
    nv_wr  = writes_nv(op_class);
    case (op_class)
      OP_ADD:  v_next = (a_msb == b_msb) && (result[WIDTH-1] != a_msb);
      OP_SUB:  v_next = (a_msb != b_msb) && (result[WIDTH-1] != a_msb);
      default: v_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_gen.sv
// Condition-flag register with a two-state FSM tracking outstanding
// multi-cycle ADD/SUB ops; flags_valid is high when no such op is pending.
module flag_gen
  import flag_gen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] result,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             mc_issue,
  input  logic             mc_done,
  input  logic             stall,
  input  logic             flush,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             flags_valid
);

  logic [0:0] state_q, state_d;
  logic       flag_wr;
  logic       n_next, v_next, z_next, nv_wr;

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .result   (result),
    .a_msb    (a_msb),
    .b_msb    (b_msb),
    .op_class (op_class),
    .n_next   (n_next),
    .v_next   (v_next),
    .z_next   (z_next),
    .nv_wr    (nv_wr)
  );

  // Next state and flag-write strobe; flush beats stall, stall beats everything else
  always_comb begin
    state_d = state_q;
    flag_wr = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (mc_issue)    state_d = ST_PEND;  // concurrent upd_en is dropped
          else if (upd_en) flag_wr = 1'b1;
        end
        default: begin
          if (mc_done) begin
            flag_wr = 1'b1;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // State and flag registers; reset abandons any pending multi-cycle op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      N       <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (flag_wr) begin
        Z <= z_next;
        if (nv_wr) begin
          N <= n_next;
          V <= v_next;
        end
      end
    end
  end

  // Pure decode of the state register
  assign flags_valid = (state_q == ST_IDLE);

endmodule

// File: tb/tb_flag_gen.sv
// Self-checking bench for flag_gen: a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_flag_gen;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             upd_en = 1'b0;
  logic [1:0]       op_class = 2'b00;
  logic [WIDTH-1:0] result = '0;
  logic             a_msb = 1'b0;
  logic             b_msb = 1'b0;
  logic             mc_issue = 1'b0;
  logic             mc_done = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             N, V, Z, flags_valid;

  int tests = 0;
  int fails = 0;

  flag_gen #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_en      (upd_en),
    .op_class    (op_class),
    .result      (result),
    .a_msb       (a_msb),
    .b_msb       (b_msb),
    .mc_issue    (mc_issue),
    .mc_done     (mc_done),
    .stall       (stall),
    .flush       (flush),
    .N           (N),
    .V           (V),
    .Z           (Z),
    .flags_valid (flags_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got NVZ/valid=%b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Flags as a pure function of the ALU transaction, overflow by sign-pattern lookup.
  logic m_n = 1'b0, m_v = 1'b0, m_z = 1'b0, m_busy = 1'b0;

  function automatic logic ovf(input logic [1:0] oc, input logic a, input logic b, input logic r);
    // Signed overflow patterns {a,b,r}: ADD 001/110, SUB (a-b) 011/100
    if (oc == 2'b00) return ({a, b, r} == 3'b001) || ({a, b, r} == 3'b110);
    if (oc == 2'b01) return ({a, b, r} == 3'b011) || ({a, b, r} == 3'b100);
    return 1'b0;
  endfunction

  task automatic model_apply();
    m_z = (result == 0);
    if (op_class < 2) begin
      m_n = result[WIDTH-1];
      m_v = ovf(op_class, a_msb, b_msb, result[WIDTH-1]);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_v = 0; m_z = 0; m_busy = 0;
    end else if (flush) begin
      m_busy = 0;
    end else if (!stall) begin
      if (m_busy && mc_done) begin
        model_apply();
        m_busy = 0;
      end else if (!m_busy && mc_issue) begin
        m_busy = 1;
      end else if (!m_busy && upd_en) begin
        model_apply();
      end
    end
  end

  // Per-cycle compare on the falling edge, away from the update edge
  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on)
      check("cycle", {N, V, Z, flags_valid}, {m_n, m_v, m_z, !m_busy});
  end

  // ---------------- stimulus ----------------
  // Present one cycle of inputs, clock it in, then return inputs to quiet.
  task automatic step(input logic upd, input logic [1:0] oc, input logic [15:0] res,
                      input logic am, input logic bm, input logic iss, input logic dn,
                      input logic st, input logic fl);
    upd_en = upd; op_class = oc; result = res; a_msb = am; b_msb = bm;
    mc_issue = iss; mc_done = dn; stall = st; flush = fl;
    @(posedge clk);
    #1;
    upd_en = 0; mc_issue = 0; mc_done = 0; stall = 0; flush = 0;
    op_class = 2'b00; result = '0; a_msb = 0; b_msb = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 16'h0000, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Power-on reset
    #12;
    check("reset_hold", {N, V, Z, flags_valid}, 4'b0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_on = 1'b1;
    idle(1);

    // ADD 0x7FFF + 0x0001 = 0x8000: N=1 V=1 Z=0
    step(1, 2'b00, 16'h8000, 0, 0, 0, 0, 0, 0);
    check("add_ovf", {N, V, Z, flags_valid}, 4'b1101);

    // LOGIC result 0: Z set, N and V held from the ADD
    step(1, 2'b10, 16'h0000, 0, 0, 0, 0, 0, 0);
    check("logic_hold_nv", {N, V, Z, flags_valid}, 4'b1111);

    // SUB 0x0005 - 0x0005 = 0: Z=1 N=0 V=0
    step(1, 2'b01, 16'h0000, 0, 0, 0, 0, 0, 0);
    check("sub_zero", {N, V, Z, flags_valid}, 4'b0011);

    // LOGIC result 0x00F0: Z=0, N and V unchanged
    step(1, 2'b10, 16'h00F0, 0, 0, 0, 0, 0, 0);
    check("logic_nz", {N, V, Z, flags_valid}, 4'b0001);

    // SHIFT result 0x8000 does not touch N
    step(1, 2'b11, 16'h8000, 1, 1, 0, 0, 0, 0);
    check("shift_z_only", {N, V, Z, flags_valid}, 4'b0001);

    // ADD negative + negative -> positive wrap (0x8000 + 0x8000 = 0x0000): V=1 Z=1
    step(1, 2'b00, 16'h0000, 1, 1, 0, 0, 0, 0);
    check("add_neg_wrap", {N, V, Z, flags_valid}, 4'b0111);

    // Multi-cycle SUB 0x8000 - 0x0001 = 0x7FFF, done 3 cycles after issue;
    // upd_en and mc_issue while pending are ignored
    step(0, 2'b00, 16'h0000, 0, 0, 1, 0, 0, 0);
    check("mc_pending", {N, V, Z, flags_valid}, 4'b0110);
    step(1, 2'b00, 16'h8000, 0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 2'b01, 16'h7FFF, 1, 0, 0, 1, 0, 0);
    check("mc_done_sub", {N, V, Z, flags_valid}, 4'b0101);

    // mc_done in IDLE is ignored
    step(0, 2'b00, 16'h0000, 0, 0, 0, 1, 0, 0);
    check("done_in_idle", {N, V, Z, flags_valid}, 4'b0101);

    // Stalled update is dropped; same op unstalled lands next cycle
    step(1, 2'b00, 16'hFFFF, 1, 1, 0, 0, 1, 0);
    check("stall_upd", {N, V, Z, flags_valid}, 4'b0101);
    step(1, 2'b00, 16'hFFFF, 1, 1, 0, 0, 0, 0);
    check("unstall_upd", {N, V, Z, flags_valid}, 4'b1001);

    // mc_issue beats a simultaneous upd_en
    step(1, 2'b10, 16'h0000, 0, 0, 1, 0, 0, 0);
    check("issue_prio", {N, V, Z, flags_valid}, 4'b1000);
    // Stalled mc_done stays pending
    step(0, 2'b00, 16'h0000, 0, 0, 0, 1, 1, 0);
    check("stall_done", {N, V, Z, flags_valid}, 4'b1000);
    // Flush under stall still returns to IDLE, flags unchanged
    step(0, 2'b00, 16'h0000, 0, 0, 0, 1, 1, 1);
    check("flush_stall", {N, V, Z, flags_valid}, 4'b1001);

    // mc_issue then flush: valid next cycle, later mc_done ignored
    step(0, 2'b00, 16'h0000, 0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 2'b00, 16'h0000, 0, 0, 0, 0, 0, 1);
    check("flush_pend", {N, V, Z, flags_valid}, 4'b1001);
    step(0, 2'b01, 16'h0000, 0, 0, 0, 1, 0, 0);
    check("done_after_flush", {N, V, Z, flags_valid}, 4'b1001);

    // Flush in IDLE suppresses a concurrent update
    step(1, 2'b01, 16'h0000, 0, 0, 0, 0, 0, 1);
    check("flush_idle", {N, V, Z, flags_valid}, 4'b1001);

    // Mid-cycle reset while pending: immediate clear, later mc_done ignored
    step(0, 2'b00, 16'h0000, 0, 0, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {N, V, Z, flags_valid}, 4'b0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 2'b01, 16'h8000, 0, 1, 0, 1, 0, 0);
    check("done_after_reset", {N, V, Z, flags_valid}, 4'b0001);

    // Short sweep of single-cycle ops checked by the model
    for (int i = 0; i < 16; i++)
      step(1, 2'(i % 4), 16'(i * 16'h1357), i[0], i[1], 0, 0, 0, 0);
    idle(2);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
